// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - MDIO opcodes, PHY register map, PHY init list and sequencer types
package mdio_pkg;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    localparam logic [4:0] REG_BMCR = 5'h00;
    localparam logic [4:0] REG_BMSR = 5'h01;
    localparam logic [4:0] REG_ANAR = 5'h04;
    localparam logic [4:0] REG_GBCR = 5'h09;

    localparam int unsigned INIT_LEN = 3;

    typedef struct packed {
        logic [4:0]  reg_addr;
        logic [15:0] data;
    } init_entry_t;

    // Drop 1000BASE-T advertisement, advertise 10/100, then restart autoneg.
    function automatic init_entry_t init_entry(input logic [1:0] idx);
        case (idx)
            2'd0:    init_entry = '{reg_addr: REG_GBCR, data: 16'h0000};
            2'd1:    init_entry = '{reg_addr: REG_ANAR, data: 16'h01E1};
            2'd2:    init_entry = '{reg_addr: REG_BMCR, data: 16'h1340};
            default: init_entry = '{reg_addr: REG_BMCR, data: 16'h0000};
        endcase
    endfunction

    typedef enum logic [2:0] {
        ST_DELAY,
        ST_ISSUE,
        ST_VERIFY_ISSUE,
        ST_POLL_ISSUE,
        ST_RD_WAIT,
        ST_POLL_WAIT,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        RD_VERIFY,
        RD_POLL_FIRST,
        RD_POLL_SECOND
    } rd_kind_t;

endpackage

// File: rtl/mdio_interval_timer.sv
// rtl/mdio_interval_timer.sv - loadable down-counter; done while the count sits at zero
module mdio_interval_timer #(
    parameter int            W         = 20,
    parameter logic [W-1:0]  RESET_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            count_q <= RESET_VAL;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/mdio_phy_ctrl.sv
// rtl/mdio_phy_ctrl.sv - drives mdio_master to init the RGMII PHY, verify it, and poll link
module mdio_phy_ctrl
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR      = 5'h00,
    parameter int unsigned STARTUP_DELAY = 20'hFFFFF,
    parameter int unsigned POLL_INTERVAL = 12_500_000,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic        clk_i,
    input  logic        rst,
    output logic [4:0]  cmd_phy_addr,
    output logic [4:0]  cmd_reg_addr,
    output logic [15:0] cmd_data,
    output logic [1:0]  cmd_opcode,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    input  logic [15:0] rd_data,
    input  logic        rd_valid,
    output logic        rd_ready,
    input  logic        restart,
    output logic        init_done,
    output logic        link_up,
    output logic        error
);

    localparam int unsigned TMR_MAX = (STARTUP_DELAY > POLL_INTERVAL) ? STARTUP_DELAY : POLL_INTERVAL;
    localparam int          TMR_W   = (TMR_MAX == 0) ? 1 : $clog2(TMR_MAX + 1);

    state_t      state_q, state_d;
    rd_kind_t    rd_kind_q, rd_kind_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  retry_q, retry_d;
    logic        pend_q, pend_d;
    logic        gap_q, gap_d;
    logic        init_done_q, init_done_d;
    logic        link_up_q, link_up_d;
    logic        error_q, error_d;
    logic        apply_restart;
    logic        accept;
    logic        tmr_load, tmr_done;
    logic [TMR_W-1:0] tmr_val;
    init_entry_t cur_entry;
    logic        unused_rd_bits;

    mdio_interval_timer #(
        .W         (TMR_W),
        .RESET_VAL (TMR_W'(STARTUP_DELAY))
    ) u_timer (
        .clk_i    (clk_i),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign cur_entry      = init_entry(idx_q);
    assign accept         = cmd_valid && cmd_ready;
    assign cmd_phy_addr   = PHY_ADDR;
    assign rd_ready       = (state_q == ST_RD_WAIT);
    assign init_done      = init_done_q;
    assign link_up        = link_up_q;
    assign error          = error_q;
    assign unused_rd_bits = ^{rd_data[15:10], rd_data[7:3], rd_data[1:0]};

    // Command fields decode straight from state, so they cannot move while cmd_valid waits.
    always_comb begin
        cmd_valid    = 1'b0;
        cmd_reg_addr = '0;
        cmd_data     = '0;
        cmd_opcode   = OP_WRITE;
        case (state_q)
            ST_ISSUE: begin
                cmd_valid    = !gap_q;
                cmd_reg_addr = cur_entry.reg_addr;
                cmd_data     = cur_entry.data;
            end
            ST_VERIFY_ISSUE: begin
                cmd_valid    = !gap_q;
                cmd_reg_addr = REG_GBCR;
                cmd_opcode   = OP_READ;
            end
            ST_POLL_ISSUE: begin
                cmd_valid    = !gap_q;
                cmd_reg_addr = REG_BMSR;
                cmd_opcode   = OP_READ;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        rd_kind_d     = rd_kind_q;
        idx_d         = idx_q;
        retry_d       = retry_q;
        pend_d        = pend_q;
        init_done_d   = init_done_q;
        link_up_d     = link_up_q;
        error_d       = error_q;
        gap_d         = accept || (state_q == ST_RD_WAIT && rd_valid);
        tmr_load      = 1'b0;
        tmr_val       = TMR_W'(STARTUP_DELAY);
        apply_restart = 1'b0;

        case (state_q)
            ST_DELAY: begin
                if (restart) begin
                    apply_restart = 1'b1;
                end else if (tmr_done) begin
                    state_d = ST_ISSUE;
                    idx_d   = '0;
                end
            end
            ST_ISSUE, ST_VERIFY_ISSUE, ST_POLL_ISSUE: begin
                // A restart only lands when no command is being offered.
                if (!cmd_valid || accept) begin
                    if (restart || pend_q) begin
                        apply_restart = 1'b1;
                    end else if (accept) begin
                        if (state_q != ST_ISSUE) begin
                            state_d = ST_RD_WAIT;
                        end else if (idx_q == 2'(INIT_LEN - 1)) begin
                            state_d   = ST_VERIFY_ISSUE;
                            rd_kind_d = RD_VERIFY;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                end else if (restart) begin
                    pend_d = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (rd_valid) begin
                    if (restart || pend_q) begin
                        apply_restart = 1'b1;
                    end else begin
                        case (rd_kind_q)
                            RD_VERIFY: begin
                                if (rd_data[9:8] == 2'b00) begin
                                    init_done_d = 1'b1;
                                    state_d     = ST_POLL_WAIT;
                                    tmr_load    = 1'b1;
                                    tmr_val     = TMR_W'(POLL_INTERVAL);
                                end else if (retry_q + 4'd1 == 4'(MAX_RETRY)) begin
                                    retry_d     = retry_q + 4'd1;
                                    error_d     = 1'b1;
                                    init_done_d = 1'b0;
                                    link_up_d   = 1'b0;
                                    state_d     = ST_ERR;
                                end else begin
                                    retry_d = retry_q + 4'd1;
                                    idx_d   = '0;
                                    state_d = ST_ISSUE;
                                end
                            end
                            // First BMSR read only clears the latched-low link bit.
                            RD_POLL_FIRST: begin
                                rd_kind_d = RD_POLL_SECOND;
                                state_d   = ST_POLL_ISSUE;
                            end
                            default: begin
                                link_up_d = rd_data[2];
                                state_d   = ST_POLL_WAIT;
                                tmr_load  = 1'b1;
                                tmr_val   = TMR_W'(POLL_INTERVAL);
                            end
                        endcase
                    end
                end else if (restart) begin
                    pend_d = 1'b1;
                end
            end
            ST_POLL_WAIT: begin
                if (restart) begin
                    apply_restart = 1'b1;
                end else if (tmr_done) begin
                    state_d   = ST_POLL_ISSUE;
                    rd_kind_d = RD_POLL_FIRST;
                end
            end
            ST_ERR: begin
                if (restart) begin
                    apply_restart = 1'b1;
                end
            end
            default: state_d = ST_DELAY;
        endcase

        if (apply_restart) begin
            state_d     = ST_DELAY;
            idx_d       = '0;
            retry_d     = '0;
            pend_d      = 1'b0;
            init_done_d = 1'b0;
            link_up_d   = 1'b0;
            error_d     = 1'b0;
            tmr_load    = 1'b1;
            tmr_val     = TMR_W'(STARTUP_DELAY);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q     <= ST_DELAY;
            rd_kind_q   <= RD_VERIFY;
            idx_q       <= '0;
            retry_q     <= '0;
            pend_q      <= 1'b0;
            gap_q       <= 1'b0;
            init_done_q <= 1'b0;
            link_up_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_kind_q   <= rd_kind_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            pend_q      <= pend_d;
            gap_q       <= gap_d;
            init_done_q <= init_done_d;
            link_up_q   <= link_up_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_mdio_phy_ctrl.sv
// tb/tb_mdio_phy_ctrl.sv - directed bench for mdio_phy_ctrl with a small mdio_master model
module tb_mdio_phy_ctrl;

    localparam logic [4:0]  PHY = 5'h03;
    localparam logic [31:0] E_W09 = 32'({2'b01, 5'h09, 16'h0000});
    localparam logic [31:0] E_W04 = 32'({2'b01, 5'h04, 16'h01E1});
    localparam logic [31:0] E_W00 = 32'({2'b01, 5'h00, 16'h1340});
    localparam logic [31:0] E_R09 = 32'({2'b10, 5'h09, 16'h0000});
    localparam logic [31:0] E_R01 = 32'({2'b10, 5'h01, 16'h0000});

    logic        clk_i = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  cmd_phy_addr, cmd_reg_addr;
    logic [15:0] cmd_data;
    logic [1:0]  cmd_opcode;
    logic        cmd_valid, rd_ready, init_done, link_up, error;
    logic        cmd_ready = 1'b1;
    logic [15:0] rd_data = 16'h0000;
    logic        rd_valid = 1'b0;
    logic        restart = 1'b0;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] xfer_log [$];
    logic [15:0] bmsr_q [$];
    logic [15:0] verify_val = 16'h0000;
    logic        rsp_hold = 1'b0;
    logic [4:0]  last_rd_reg = 5'h00;
    logic        xfer_prev = 1'b0;
    logic        hold_prev = 1'b0;
    logic [31:0] pay_prev = '0;
    logic [31:0] init_seq [4];

    always #4 clk_i = ~clk_i;

    mdio_phy_ctrl #(
        .PHY_ADDR      (PHY),
        .STARTUP_DELAY (10),
        .POLL_INTERVAL (50),
        .MAX_RETRY     (3)
    ) dut (
        .clk_i        (clk_i),
        .rst          (rst),
        .cmd_phy_addr (cmd_phy_addr),
        .cmd_reg_addr (cmd_reg_addr),
        .cmd_data     (cmd_data),
        .cmd_opcode   (cmd_opcode),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .restart      (restart),
        .init_done    (init_done),
        .link_up      (link_up),
        .error        (error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pay();
        return 32'({cmd_opcode, cmd_reg_addr, cmd_data});
    endfunction

    // Transfer log plus gap-after-transfer and hold-while-stalled properties.
    always @(negedge clk_i) begin
        if (xfer_prev) chk("gap_after_xfer", 32'(cmd_valid), 32'd0);
        if (hold_prev) chk("hold_while_stalled", {7'd0, cmd_valid, pay()[23:0]}, {7'd0, 1'b1, pay_prev[23:0]});
        xfer_prev <= cmd_valid && cmd_ready && !rst;
        hold_prev <= cmd_valid && !cmd_ready && !rst;
        pay_prev  <= pay();
        if (cmd_valid && cmd_ready && !rst) begin
            xfer_log.push_back(pay());
            if (cmd_opcode == 2'b10) last_rd_reg <= cmd_reg_addr;
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (rd_ready && !rsp_hold) begin
                @(posedge clk_i); #1;
                rd_valid = 1'b1;
                if (last_rd_reg == 5'h09)      rd_data = verify_val;
                else if (bmsr_q.size() > 0)    rd_data = bmsr_q.pop_front();
                else                           rd_data = 16'h7809;
                @(posedge clk_i); #1;
                rd_valid = 1'b0;
                rd_data  = 16'h0000;
            end
        end
    end

    task automatic pulse_restart();
        @(posedge clk_i); #1 restart = 1'b1;
        @(posedge clk_i); #1 restart = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (cmd_valid) break;
        end
        chk(tag, 32'(cmd_valid), 32'd1);
    endtask

    task automatic wait_rd_hs(input string tag, input int n, input int budget);
        int cnt = 0;
        for (int i = 0; i < budget && cnt < n; i++) begin
            @(negedge clk_i);
            if (rd_valid && rd_ready) cnt++;
        end
        chk(tag, cnt, n);
    endtask

    task automatic count_rise(input string tag, input int exp);
        int cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_i); #1;
            cnt++;
            if (cmd_valid) break;
        end
        chk(tag, cnt, exp);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(cmd_valid), 32'd0);
        chk({tag, "_rd_ready"}, 32'(rd_ready), 32'd0);
        chk({tag, "_flags"}, 32'({init_done, link_up, error}), 32'd0);
        chk({tag, "_payload"}, pay(), 32'({2'b01, 5'h00, 16'h0000}));
        chk({tag, "_phy_addr"}, 32'(cmd_phy_addr), 32'(PHY));
    endtask

    initial begin
        int base;
        int seen;
        init_seq = '{E_W09, E_W04, E_W00, E_R09};
        bmsr_q   = '{16'h7809, 16'h780D, 16'h7809, 16'h7809};

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk_reset_vals("reset");

        // Boot: first command STARTUP_DELAY+1 cycles after rst falls, list in order, verify.
        @(posedge clk_i); #1 rst = 1'b0;
        count_rise("boot_first_valid_cycles", 11);
        chk("boot_first_payload", pay(), E_W09);
        wait_rd_hs("boot_verify_hs", 1, 100);
        chk("boot_init_done_before", 32'(init_done), 32'd0);
        @(posedge clk_i); #1;
        chk("boot_init_done_after", 32'(init_done), 32'd1);
        for (int i = 0; i < 4; i++) chk($sformatf("boot_xfer%0d", i), xfer_log[i], init_seq[i]);

        // Link poll: first pair 7809/780D raises link, next 7809/7809 drops it.
        count_rise("poll_first_valid_cycles", 51);
        wait_rd_hs("poll1_hs", 2, 100);
        chk("poll1_link_before", 32'(link_up), 32'd0);
        @(posedge clk_i); #1;
        chk("poll1_link_after", 32'(link_up), 32'd1);
        chk("poll1_xfer_a", xfer_log[4], E_R01);
        chk("poll1_xfer_b", xfer_log[5], E_R01);
        wait_rd_hs("poll2_hs", 2, 200);
        chk("poll2_link_before", 32'(link_up), 32'd1);
        @(posedge clk_i); #1;
        chk("poll2_link_after", 32'(link_up), 32'd0);

        // Back-pressure on the 2nd write, then restart while the 3rd write is stalled.
        cmd_ready = 1'b0;
        pulse_restart();
        chk("bp_init_done_cleared", 32'(init_done), 32'd0);
        base = xfer_log.size();
        wait_valid("bp_w1_valid", 50);
        chk("bp_w1_payload", pay(), E_W09);
        @(posedge clk_i); #1 cmd_ready = 1'b1;
        @(posedge clk_i); #1 cmd_ready = 1'b0;
        wait_valid("bp_w2_valid", 10);
        repeat (20) begin
            @(negedge clk_i);
            chk("bp_w2_stable", {7'd0, cmd_valid, pay()[23:0]}, {7'd0, 1'b1, E_W04[23:0]});
        end
        @(posedge clk_i); #1 cmd_ready = 1'b1;
        @(posedge clk_i); #1 cmd_ready = 1'b0;
        wait_valid("rs_w3_valid", 10);
        chk("rs_w3_payload", pay(), E_W00);
        pulse_restart();
        repeat (3) begin
            @(negedge clk_i);
            chk("rs_w3_stable", {7'd0, cmd_valid, pay()[23:0]}, {7'd0, 1'b1, E_W00[23:0]});
        end
        @(posedge clk_i); #1 cmd_ready = 1'b1;
        @(posedge clk_i); #1;
        chk("rs_valid_after_xfer", 32'(cmd_valid), 32'd0);
        chk("rs_init_done", 32'(init_done), 32'd0);
        chk("rs_xfer_count", xfer_log.size() - base, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("rs_xfer%0d", i), xfer_log[base + i], init_seq[i]);
        count_rise("rs_rerun_valid_cycles", 11);
        chk("rs_rerun_payload", pay(), E_W09);
        wait_rd_hs("rs_verify_hs", 1, 100);
        @(posedge clk_i); #1;
        chk("rs_init_done_after", 32'(init_done), 32'd1);

        // Verify always fails: list sent MAX_RETRY times, then sticky error.
        verify_val = 16'h0300;
        pulse_restart();
        base = xfer_log.size();
        for (int i = 0; i < 400 && !error; i++) @(negedge clk_i);
        chk("vf_error", 32'(error), 32'd1);
        chk("vf_init_done", 32'(init_done), 32'd0);
        chk("vf_xfer_count", xfer_log.size() - base, 12);
        for (int i = 0; i < 12; i++) chk($sformatf("vf_xfer%0d", i), xfer_log[base + i], init_seq[i % 4]);
        seen = 0;
        repeat (60) begin
            @(negedge clk_i);
            if (cmd_valid) seen++;
        end
        chk("vf_no_cmd_in_err", seen, 0);
        chk("vf_error_sticky", 32'(error), 32'd1);
        verify_val = 16'h0000;
        pulse_restart();
        chk("vf_error_cleared", 32'(error), 32'd0);

        // Reset while waiting on a read response.
        rsp_hold = 1'b1;
        for (int i = 0; i < 100 && !rd_ready; i++) @(negedge clk_i);
        chk("rr_in_rd_wait", 32'(rd_ready), 32'd1);
        @(posedge clk_i); #1 rst = 1'b1;
        @(posedge clk_i); #1;
        chk_reset_vals("rr");
        rst = 1'b0;
        rsp_hold = 1'b0;
        for (int i = 0; i < 200 && !init_done; i++) @(negedge clk_i);
        chk("rr_reboot_init_done", 32'(init_done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
